// File: rtl/tile_io_router_pkg.sv
// Shared definitions for the tile neighbour I/O router.
//   - location code helpers as functions of the channel count
//   - router FSM state encoding
//   - word_t, the default-width data word
// Optional build macro TILE_IO_ROUTER_RR_EN (used by the arbiter) selects
// round-robin ANY arbitration instead of lowest-index-first.
package tile_io_router_pkg;

    localparam int DEF_WORD_W = 16;

    typedef logic [DEF_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_RECV  = 2'd2,
        ST_RDONE = 2'd3
    } router_state_t;

    // Codes 0..nch-1 address a channel directly; the special codes follow.
    function automatic int LOC_NIL(input int nch);
        return nch;
    endfunction

    function automatic int LOC_ACC(input int nch);
        return nch + 1;
    endfunction

    function automatic int LOC_ANY(input int nch);
        return nch + 2;
    endfunction

    function automatic int LOC_LAST(input int nch);
        return nch + 3;
    endfunction

endpackage

// File: rtl/tile_io_router_if.sv
// Bundle of core-side and neighbour-channel signals of the tile I/O router.
//   master : environment view (tile core + neighbours), drives requests,
//            outbound words and channel completions
//   slave  : router view, drives completions, received data and the
//            per-channel offers/readies
// Channel vectors are packed with channel k in bits [k*WORD_W +: WORD_W].
interface tile_io_router_if #(
    parameter int NCH    = 4,
    parameter int WORD_W = 16
);
    localparam int LOC_W = $clog2(NCH + 4);

    logic [LOC_W-1:0]      loc;
    logic                  send;
    logic [WORD_W-1:0]     send_data;
    logic                  send_done;
    logic                  recv;
    logic [WORD_W-1:0]     recv_data;
    logic                  recv_valid;
    logic [NCH*WORD_W-1:0] ch_send_data;
    logic [NCH-1:0]        ch_send_ready;
    logic [NCH-1:0]        ch_send_done;
    logic [NCH*WORD_W-1:0] ch_recv_data;
    logic [NCH-1:0]        ch_recv_valid;
    logic [NCH-1:0]        ch_recv_ready;

    modport master (
        output loc, send, send_data, recv,
        output ch_send_done, ch_recv_data, ch_recv_valid,
        input  send_done, recv_data, recv_valid,
        input  ch_send_data, ch_send_ready, ch_recv_ready
    );

    modport slave (
        input  loc, send, send_data, recv,
        input  ch_send_done, ch_recv_data, ch_recv_valid,
        output send_done, recv_data, recv_valid,
        output ch_send_data, ch_send_ready, ch_recv_ready
    );

endinterface

// File: rtl/tile_io_router_any_arb.sv
// tile_io_any_arb: combinational arbiter that resolves the ANY location.
//   i_req    : request vector, one bit per channel
//   i_rrBase : first channel considered (only with TILE_IO_ROUTER_RR_EN)
//   o_grant  : one-hot grant
//   o_idx    : index of the granted channel
//   o_valid  : at least one request present
// Macro TILE_IO_ROUTER_RR_EN: defined -> search starts at i_rrBase,
// undefined -> search starts at channel 0 (lowest index wins).
module tile_io_any_arb
    import tile_io_router_pkg::*;
#(
    parameter  int NCH   = 4,
    localparam int IDX_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]   i_req,
`ifdef TILE_IO_ROUTER_RR_EN
    input  logic [IDX_W-1:0] i_rrBase,
`endif
    output logic [NCH-1:0]   o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int               w_base;
    int               w_pos;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Walk the channels once, starting at the priority base and wrapping,
    // and grant the first requester met.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_cand  = '0;
`ifdef TILE_IO_ROUTER_RR_EN
        w_base  = int'(i_rrBase);
`else
        w_base  = 0;
`endif
        for (int k = 0; k < NCH; k++) begin
            w_pos = w_base + k;
            if (w_pos >= NCH) begin
                w_pos = w_pos - NCH;
            end
            w_cand = IDX_W'(w_pos);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

    assign o_valid = w_found;

endmodule

// File: rtl/tile_io_router.sv
// tile_io_router: connects one tile core to NCH neighbour channels.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tile_io_router_if.slave carrying the core request/response
//              signals (loc, send, send_data, send_done, recv, recv_data,
//              recv_valid) and the per-channel link signals (ch_send_data,
//              ch_send_ready, ch_send_done, ch_recv_data, ch_recv_valid,
//              ch_recv_ready)
// A send/recv request is latched with its resolved target and held until
// the neighbour completes it or the core drops the request. Received words
// are registered and returned one cycle after the channel handshake.
// Macro TILE_IO_ROUTER_RR_EN enables round-robin ANY arbitration (rr_q);
// without it ANY picks the lowest-index channel.
module tile_io_router
    import tile_io_router_pkg::*;
#(
    parameter  int NCH    = 4,
    parameter  int WORD_W = DEF_WORD_W,
    localparam int LOC_W  = $clog2(NCH + 4),
    localparam int IDX_W  = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    tile_io_router_if.slave bus
);

    localparam logic [LOC_W-1:0] L_NIL  = LOC_W'(LOC_NIL(NCH));
    localparam logic [LOC_W-1:0] L_ACC  = LOC_W'(LOC_ACC(NCH));
    localparam logic [LOC_W-1:0] L_ANY  = LOC_W'(LOC_ANY(NCH));
    localparam logic [LOC_W-1:0] L_LAST = LOC_W'(LOC_LAST(NCH));

    router_state_t     r_state, w_stateNxt;
    logic [WORD_W-1:0] r_data, w_dataNxt;
    logic [IDX_W-1:0]  r_tgt, w_tgtNxt;
    logic              r_any, w_anyNxt;
    logic [LOC_W-1:0]  r_last, w_lastNxt;
`ifdef TILE_IO_ROUTER_RR_EN
    logic [IDX_W-1:0]  r_rr, w_rrNxt;
`endif

    logic              w_resNil;
    logic              w_resAny;
    logic [IDX_W-1:0]  w_resCh;

    logic [NCH-1:0]    w_arbReq;
    logic [NCH-1:0]    w_arbGrant;
    logic [IDX_W-1:0]  w_arbIdx;
    logic              w_arbValid;
    logic [IDX_W-1:0]  w_arbIdxInc;

    logic                  w_sendDone;
    logic [WORD_W-1:0]     w_recvData;
    logic                  w_recvValid;
    logic [NCH*WORD_W-1:0] w_chSendData;
    logic [NCH-1:0]        w_chSendReady;
    logic [NCH-1:0]        w_chRecvReady;

    // Translate the location code into a channel index, ANY or NIL.
    // ACC maps to channel 0; LAST follows the last completed transfer and
    // falls back to NIL until one has completed; unknown codes are NIL.
    always_comb begin
        w_resNil = 1'b0;
        w_resAny = 1'b0;
        w_resCh  = '0;
        if (bus.loc < LOC_W'(NCH)) begin
            w_resCh = bus.loc[IDX_W-1:0];
        end else if (bus.loc == L_ACC) begin
            w_resCh = '0;
        end else if (bus.loc == L_ANY) begin
            w_resAny = 1'b1;
        end else if (bus.loc == L_LAST && r_last != L_NIL) begin
            w_resCh = r_last[IDX_W-1:0];
        end else begin
            w_resNil = 1'b1;
        end
    end

    tile_io_any_arb #(
        .NCH(NCH)
    ) u_arb (
        .i_req    (w_arbReq),
`ifdef TILE_IO_ROUTER_RR_EN
        .i_rrBase (r_rr),
`endif
        .o_grant  (w_arbGrant),
        .o_idx    (w_arbIdx),
        .o_valid  (w_arbValid)
    );

    assign w_arbIdxInc = (w_arbIdx == IDX_W'(NCH - 1)) ? '0 : w_arbIdx + 1'b1;

    // Next-state and output decode. Channel signals are only driven while
    // the core still holds the matching request, so a dropped request can
    // never complete behind the core's back.
    always_comb begin
        w_stateNxt    = r_state;
        w_dataNxt     = r_data;
        w_tgtNxt      = r_tgt;
        w_anyNxt      = r_any;
        w_lastNxt     = r_last;
`ifdef TILE_IO_ROUTER_RR_EN
        w_rrNxt       = r_rr;
`endif
        w_arbReq      = '0;
        w_sendDone    = 1'b0;
        w_recvData    = '0;
        w_recvValid   = 1'b0;
        w_chSendData  = '0;
        w_chSendReady = '0;
        w_chRecvReady = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.send) begin
                    if (w_resNil) begin
                        w_sendDone = 1'b1;
                    end else begin
                        w_dataNxt  = bus.send_data;
                        w_tgtNxt   = w_resCh;
                        w_anyNxt   = w_resAny;
                        w_stateNxt = ST_SEND;
                    end
                end else if (bus.recv) begin
                    if (w_resNil) begin
                        w_recvValid = 1'b1;
                    end else begin
                        w_tgtNxt   = w_resCh;
                        w_anyNxt   = w_resAny;
                        w_stateNxt = ST_RECV;
                    end
                end
            end
            ST_SEND: begin
                if (!bus.send) begin
                    w_stateNxt = ST_IDLE;
                end else if (r_any) begin
                    w_chSendReady = '1;
                    for (int k = 0; k < NCH; k++) begin
                        w_chSendData[k*WORD_W +: WORD_W] = r_data;
                    end
                    w_arbReq = bus.ch_send_done;
                    if (w_arbValid) begin
                        w_sendDone = 1'b1;
                        w_lastNxt  = LOC_W'(w_arbIdx);
`ifdef TILE_IO_ROUTER_RR_EN
                        w_rrNxt    = w_arbIdxInc;
`endif
                        w_stateNxt = ST_IDLE;
                    end
                end else begin
                    w_chSendReady[r_tgt]                       = 1'b1;
                    w_chSendData[int'(r_tgt)*WORD_W +: WORD_W] = r_data;
                    if (bus.ch_send_done[r_tgt]) begin
                        w_sendDone = 1'b1;
                        w_lastNxt  = LOC_W'(r_tgt);
                        w_stateNxt = ST_IDLE;
                    end
                end
            end
            ST_RECV: begin
                if (!bus.recv) begin
                    w_stateNxt = ST_IDLE;
                end else if (r_any) begin
                    w_arbReq = bus.ch_recv_valid;
                    if (w_arbValid) begin
                        w_chRecvReady = w_arbGrant;
                        w_dataNxt     = bus.ch_recv_data[int'(w_arbIdx)*WORD_W +: WORD_W];
                        w_lastNxt     = LOC_W'(w_arbIdx);
`ifdef TILE_IO_ROUTER_RR_EN
                        w_rrNxt       = w_arbIdxInc;
`endif
                        w_stateNxt    = ST_RDONE;
                    end
                end else begin
                    w_chRecvReady[r_tgt] = 1'b1;
                    if (bus.ch_recv_valid[r_tgt]) begin
                        w_dataNxt  = bus.ch_recv_data[int'(r_tgt)*WORD_W +: WORD_W];
                        w_lastNxt  = LOC_W'(r_tgt);
                        w_stateNxt = ST_RDONE;
                    end
                end
            end
            ST_RDONE: begin
                w_recvValid = 1'b1;
                w_recvData  = r_data;
                w_stateNxt  = ST_IDLE;
            end
            default: begin
                w_stateNxt = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_tgt   <= '0;
            r_any   <= 1'b0;
            r_last  <= L_NIL;
        end else begin
            r_state <= w_stateNxt;
            r_data  <= w_dataNxt;
            r_tgt   <= w_tgtNxt;
            r_any   <= w_anyNxt;
            r_last  <= w_lastNxt;
        end
    end

`ifdef TILE_IO_ROUTER_RR_EN
    // Round-robin pointer: next ANY search starts after the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= '0;
        end else begin
            r_rr <= w_rrNxt;
        end
    end
`endif

    assign bus.send_done     = w_sendDone;
    assign bus.recv_data     = w_recvData;
    assign bus.recv_valid    = w_recvValid;
    assign bus.ch_send_data  = w_chSendData;
    assign bus.ch_send_ready = w_chSendReady;
    assign bus.ch_recv_ready = w_chRecvReady;

endmodule

// File: tb/tb_tile_io_router.sv
// Directed testbench for tile_io_router with NCH=4, WORD_W=16.
// Expected values are hand-derived; the repeated ANY receive expectation
// depends on TILE_IO_ROUTER_RR_EN.
module tb_tile_io_router;
    import tile_io_router_pkg::*;

    localparam int NCH    = 4;
    localparam int WORD_W = 16;

    localparam logic [2:0] L_NIL  = 3'(LOC_NIL(NCH));
    localparam logic [2:0] L_ACC  = 3'(LOC_ACC(NCH));
    localparam logic [2:0] L_ANY  = 3'(LOC_ANY(NCH));
    localparam logic [2:0] L_LAST = 3'(LOC_LAST(NCH));

`ifdef TILE_IO_ROUTER_RR_EN
    localparam logic [3:0] EXP_ANY2_READY = 4'b0100;
    localparam word_t      EXP_ANY2_DATA  = 16'h0022;
`else
    localparam logic [3:0] EXP_ANY2_READY = 4'b0010;
    localparam word_t      EXP_ANY2_DATA  = 16'h0011;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   failCount  = 0;

    tile_io_router_if #(.NCH(NCH), .WORD_W(WORD_W)) bus();

    tile_io_router #(
        .NCH    (NCH),
        .WORD_W (WORD_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [2:0] l, input word_t d);
        bus.send      = s;
        bus.recv      = r;
        bus.loc       = l;
        bus.send_data = d;
    endtask

    task automatic driveChannels(input logic [3:0] sendDone, input logic [3:0] recvValid,
                                 input logic [63:0] recvData);
        bus.ch_send_done  = sendDone;
        bus.ch_recv_valid = recvValid;
        bus.ch_recv_data  = recvData;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence; each step drives inputs just after a rising edge
    // and samples outputs a little later in the same cycle.
    initial begin
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        driveChannels(4'b0, 4'b0, 64'h0);
        rst = 1'b1;
        nextCycle();
        nextCycle();
        #1;
        checkOutput("rst ch_send_ready", bus.ch_send_ready, 64'h0);
        checkOutput("rst ch_recv_ready", bus.ch_recv_ready, 64'h0);
        checkOutput("rst send_done", bus.send_done, 64'h0);
        checkOutput("rst recv_valid", bus.recv_valid, 64'h0);
        checkOutput("rst ch_send_data", bus.ch_send_data, 64'h0);
        rst = 1'b0;
        nextCycle();

        // LAST right after reset behaves as NIL
        applyStimulus(1'b0, 1'b1, L_LAST, 16'h0);
        #1;
        checkOutput("last-nil recv_valid", bus.recv_valid, 64'h1);
        checkOutput("last-nil recv_data", bus.recv_data, 64'h0);
        checkOutput("last-nil ch_recv_ready", bus.ch_recv_ready, 64'h0);
        nextCycle();

        // NIL send and receive complete in the same cycle
        applyStimulus(1'b1, 1'b0, L_NIL, 16'hFFFF);
        #1;
        checkOutput("nil send_done", bus.send_done, 64'h1);
        checkOutput("nil ch_send_ready", bus.ch_send_ready, 64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, L_NIL, 16'h0);
        #1;
        checkOutput("nil recv_valid", bus.recv_valid, 64'h1);
        checkOutput("nil recv_data", bus.recv_data, 64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);

        // Fixed-target send to channel 2; loc/data changes are ignored
        applyStimulus(1'b1, 1'b0, 3'd2, 16'h1234);
        #1;
        checkOutput("fix idle send_done", bus.send_done, 64'h0);
        checkOutput("fix idle ch_send_ready", bus.ch_send_ready, 64'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'd0, 16'h9999);
        #1;
        checkOutput("fix ch_send_ready", bus.ch_send_ready, 64'h4);
        checkOutput("fix ch_send_data", bus.ch_send_data, 64'h0000_1234_0000_0000);
        checkOutput("fix wait send_done", bus.send_done, 64'h0);
        nextCycle();
        nextCycle();
        driveChannels(4'b0100, 4'b0, 64'h0);
        #1;
        checkOutput("fix send_done", bus.send_done, 64'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        driveChannels(4'b0, 4'b0, 64'h0);
        #1;
        checkOutput("fix after send_done", bus.send_done, 64'h0);
        checkOutput("fix after ch_send_ready", bus.ch_send_ready, 64'h0);

        // Receive from LAST (channel 2), data back one cycle after handshake
        applyStimulus(1'b0, 1'b1, L_LAST, 16'h0);
        #1;
        checkOutput("rlast idle ch_recv_ready", bus.ch_recv_ready, 64'h0);
        nextCycle();
        checkOutput("rlast ch_recv_ready", bus.ch_recv_ready, 64'h4);
        checkOutput("rlast wait recv_valid", bus.recv_valid, 64'h0);
        driveChannels(4'b0, 4'b0100, 64'h0000_BEEF_0000_0000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        driveChannels(4'b0, 4'b0, 64'h0);
        #1;
        checkOutput("rlast recv_valid", bus.recv_valid, 64'h1);
        checkOutput("rlast recv_data", bus.recv_data, 64'hBEEF);
        checkOutput("rlast rdone ch_recv_ready", bus.ch_recv_ready, 64'h0);
        nextCycle();
        checkOutput("rlast after recv_valid", bus.recv_valid, 64'h0);
        checkOutput("rlast after recv_data", bus.recv_data, 64'h0);

        // ANY receive with channels 1 and 2 valid
        applyStimulus(1'b0, 1'b1, L_ANY, 16'h0);
        driveChannels(4'b0, 4'b0110, 64'h0000_0022_0011_0000);
        nextCycle();
        checkOutput("any1 ch_recv_ready", bus.ch_recv_ready, 64'h2);
        nextCycle();
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        #1;
        checkOutput("any1 recv_valid", bus.recv_valid, 64'h1);
        checkOutput("any1 recv_data", bus.recv_data, 64'h0011);
        nextCycle();
        applyStimulus(1'b0, 1'b1, L_ANY, 16'h0);
        nextCycle();
        checkOutput("any2 ch_recv_ready", bus.ch_recv_ready, 64'(EXP_ANY2_READY));
        nextCycle();
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        driveChannels(4'b0, 4'b0, 64'h0);
        #1;
        checkOutput("any2 recv_valid", bus.recv_valid, 64'h1);
        checkOutput("any2 recv_data", bus.recv_data, 64'(EXP_ANY2_DATA));
        nextCycle();

        // Send to channel 3, then LAST targets channel 3; drop it (abort)
        applyStimulus(1'b1, 1'b0, 3'd3, 16'h5A5A);
        nextCycle();
        driveChannels(4'b1000, 4'b0, 64'h0);
        #1;
        checkOutput("ch3 send_done", bus.send_done, 64'h1);
        checkOutput("ch3 ch_send_data", bus.ch_send_data, 64'h5A5A_0000_0000_0000);
        nextCycle();
        driveChannels(4'b0, 4'b0, 64'h0);
        applyStimulus(1'b1, 1'b0, L_LAST, 16'h7777);
        nextCycle();
        checkOutput("slast ch_send_ready", bus.ch_send_ready, 64'h8);
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        #1;
        checkOutput("slast drop ch_send_ready", bus.ch_send_ready, 64'h0);
        checkOutput("slast drop send_done", bus.send_done, 64'h0);
        nextCycle();

        // Abort of a fixed send to channel 1 after two cycles
        applyStimulus(1'b1, 1'b0, 3'd1, 16'h4321);
        nextCycle();
        checkOutput("abort ch_send_ready", bus.ch_send_ready, 64'h2);
        nextCycle();
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        nextCycle();
        checkOutput("abort after ch_send_ready", bus.ch_send_ready, 64'h0);
        checkOutput("abort after send_done", bus.send_done, 64'h0);
        applyStimulus(1'b1, 1'b0, L_LAST, 16'h0);
        nextCycle();
        checkOutput("abort last kept", bus.ch_send_ready, 64'h8);
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        nextCycle();

        // ACC resolves to channel 0
        applyStimulus(1'b1, 1'b0, L_ACC, 16'h0ACC);
        nextCycle();
        checkOutput("acc ch_send_ready", bus.ch_send_ready, 64'h1);
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        nextCycle();

        // ANY send: offered everywhere, channels 1 and 2 complete together
        applyStimulus(1'b1, 1'b0, L_ANY, 16'hC0DE);
        nextCycle();
        checkOutput("sany ch_send_ready", bus.ch_send_ready, 64'hF);
        checkOutput("sany ch_send_data", bus.ch_send_data, 64'hC0DE_C0DE_C0DE_C0DE);
        driveChannels(4'b0110, 4'b0, 64'h0);
        #1;
        checkOutput("sany send_done", bus.send_done, 64'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        driveChannels(4'b0, 4'b0, 64'h0);
        applyStimulus(1'b1, 1'b0, L_LAST, 16'h0);
        nextCycle();
        checkOutput("sany winner via last", bus.ch_send_ready, 64'h2);
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        nextCycle();

        // Simultaneous send and recv: send first, recv only afterwards
        applyStimulus(1'b1, 1'b1, 3'd0, 16'hAAAA);
        nextCycle();
        checkOutput("both ch_send_ready", bus.ch_send_ready, 64'h1);
        checkOutput("both ch_recv_ready", bus.ch_recv_ready, 64'h0);
        driveChannels(4'b0001, 4'b0, 64'h0);
        #1;
        checkOutput("both send_done", bus.send_done, 64'h1);
        checkOutput("both done ch_recv_ready", bus.ch_recv_ready, 64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'd0, 16'h0);
        driveChannels(4'b0, 4'b0, 64'h0);
        nextCycle();
        checkOutput("both recv ch_recv_ready", bus.ch_recv_ready, 64'h1);

        // Reset while in RECV with a word arriving: word is discarded
        driveChannels(4'b0, 4'b0001, 64'h0000_0000_0000_1111);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, L_NIL, 16'h0);
        nextCycle();
        checkOutput("mrst ch_recv_ready", bus.ch_recv_ready, 64'h0);
        checkOutput("mrst ch_send_ready", bus.ch_send_ready, 64'h0);
        checkOutput("mrst recv_valid", bus.recv_valid, 64'h0);
        checkOutput("mrst recv_data", bus.recv_data, 64'h0);
        rst = 1'b0;
        driveChannels(4'b0, 4'b0, 64'h0);
        nextCycle();
        checkOutput("mrst after recv_valid", bus.recv_valid, 64'h0);
        checkOutput("mrst after recv_data", bus.recv_data, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/tile_io_router.md
Name: tile_io_router

Overview:
- Parametrised successor of the tile neighbour-I/O block. Connects one tile core to NCH neighbour channels instead of a fixed four.
- Latches each send/recv transaction and holds it until the neighbour completes it. Registers received data.
- Resolves ANY with a round-robin arbiter. LAST tracks the last *completed* transfer.
- Sits between the tile execution core and the per-channel tile link signals.

Parameters:
- NCH, 4, number of neighbour channels, 2..8.
- WORD_W, 16, data word width.
- LOC_W, $clog2(NCH+4), location code width; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- loc  in  LOC_W  target location code
- send  in  1  core send request; held until send_done or abort
- send_data  in  WORD_W  word to send
- send_done  out  1  single-cycle send completion
- recv  in  1  core receive request; held until recv_valid or abort
- recv_data  out  WORD_W  received word; valid only with recv_valid, else 0
- recv_valid  out  1  single-cycle receive completion
- ch_send_data  out  NCH*WORD_W  per-channel outbound word
- ch_send_ready  out  NCH  per-channel send offer
- ch_send_done  in  NCH  neighbour accepted the word
- ch_recv_data  in  NCH*WORD_W  per-channel inbound word
- ch_recv_valid  in  NCH  neighbour has a word
- ch_recv_ready  out  NCH  router takes the word

Behaviour:
- Location codes:
  - 0..NCH-1 = channel index.
  - NCH = NIL, NCH+1 = ACC (resolves to channel 0), NCH+2 = ANY, NCH+3 = LAST.
  - LAST while last_q==NIL behaves as NIL.
- FSM states: IDLE, SEND, RECV, RDONE.
- Reset:
  - state=IDLE, last_q=NIL, rr_q=0, data_q=0.
  - All outputs 0.
- IDLE:
  - send has priority over recv when both are asserted.
  - send to NIL: send_done=1 combinationally this cycle; stay IDLE.
  - recv from NIL: recv_valid=1, recv_data=0 this cycle; stay IDLE.
  - Otherwise: latch data_q=send_data and tgt_q=resolved channel (or ANY flag); go to SEND or RECV.
  - No channel output is driven in IDLE.
- SEND, fixed target:
  - Drive ch_send_ready[tgt_q]=1 and ch_send_data[tgt_q]=data_q.
  - On ch_send_done[tgt_q]: send_done=1 in the same cycle, last_q<=tgt_q, go to IDLE.
- SEND, ANY:
  - Offer on all channels: ch_send_ready all 1, every ch_send_data=data_q.
  - The arbiter picks one channel among the ch_send_done bits.
  - That completion: send_done=1, last_q<=winner, rr_q<=winner+1 (mod NCH).
- RECV, fixed target:
  - ch_recv_ready[tgt_q]=1.
  - On ch_recv_valid[tgt_q]: data_q<=ch_recv_data[tgt_q], last_q<=tgt_q, go to RDONE.
- RECV, ANY:
  - Arbiter grants one channel among ch_recv_valid each cycle.
  - ch_recv_ready is asserted only on the granted channel, and only if any valid is set.
  - Handshake completes as for a fixed target; also rr_q<=grant+1 (mod NCH).
- RDONE:
  - recv_valid=1, recv_data=data_q for exactly one cycle, then IDLE.
  - Receive latency = 1 cycle after the channel handshake.
- Abort:
  - Core deasserts the active request in SEND/RECV before completion → next cycle IDLE.
  - No done pulse; last_q and rr_q unchanged.
- Other rules:
  - loc changes while in SEND/RECV are ignored; target is latched.
  - Illegal loc codes (> NCH+3) behave as NIL.
  - rst mid-transaction: reset values at the next clk edge; an in-flight word is discarded.

Optional Feature:
- Macro: TILE_IO_ROUTER_RR_EN.
- Defined: ANY arbitration is round-robin starting at rr_q.
- Undefined: fixed priority, lowest index wins. rr_q is not instantiated. Matches previous-generation ordering.

Decomposition:
- Shared package holds:
  - location code constants as functions of NCH (LOC_NIL, LOC_ACC, LOC_ANY, LOC_LAST);
  - router state enum;
  - word_t for WORD_W.
- One natural sub-module: tile_io_any_arb. Combinational: request vector plus rr pointer → one-hot grant and index. The macro only changes its priority base.

Test Plan (NCH=4, WORD_W=16):
- Fixed-target send:
  - Stimulus: send, loc=2, data 0x1234; ch_send_done[2] raised 3 cycles later.
  - Response: ch_send_ready=4'b0100 and ch_send_data[2]=0x1234 from the next cycle; send_done pulses in the done cycle; then recv loc=LAST drives ch_recv_ready[2].
- ANY receive:
  - Stimulus: recv loc=ANY, ch_recv_valid=4'b0110, ch1=0x0011, ch2=0x0022.
  - Response: recv_valid one cycle after the handshake with 0x0011. A repeated recv ANY returns 0x0022 with RR_EN, 0x0011 without.
- NIL:
  - send loc=NIL → send_done same cycle, ch_send_ready=0.
  - recv loc=NIL → recv_valid same cycle, recv_data=0.
- LAST after reset:
  - recv loc=LAST → NIL behaviour.
  - After send to ch3 completes, send loc=LAST drives ch_send_ready=4'b1000.
- Abort and reset:
  - send loc=1, no done, send dropped after 2 cycles → ch_send_ready=0 next cycle, no send_done, last unchanged.
  - rst asserted in RECV → all outputs 0 after the edge.
- Simultaneous requests:
  - send and recv both asserted, loc=0 → SEND entered; ch_recv_ready stays 0 until send_done.
